hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Decodes Instr_D/Instr_E/Instr_M into Tuse/Tnew and detects load-use and RAW hazards that forwarding cannot resolve.
- Tracks the multi-cycle mult/div unit busy window and drives the PC enable, F/D hold, and the clr inputs of the F/D, D/E and E/M pipeline registers.
- Applies exception flush priority.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu.
- DIV_CYC, 10, busy cycles for div/divu.
- CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- Instr_D  in  32  instruction in D stage.
- Instr_E  in  32  instruction in E stage.
- Instr_M  in  32  instruction in M stage.
- IntReq  in  1  exception/interrupt taken at M stage (from CP0).
- stall_PC  out  1  1 = hold PC.
- stall_FD  out  1  1 = hold F/D register.
- clr_FD  out  1  1 = flush F/D register.
- clr_DE  out  1  1 = flush D/E register (bubble).
- clr_EM  out  1  1 = flush E/M register.
- md_start  out  1  E-stage mult/div issuing this cycle.
- md_busy  out  1  mult/div unit busy (registered).
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Decode:
  - load: op 0x20/0x21/0x23/0x24/0x25.
  - store: op 0x28/0x29/0x2B.
  - beq/bne: op 0x04/0x05.
  - R-type: op 0x00.
  - jr/jalr: funct 0x08/0x09.
  - md: funct 0x18–0x1B (mult/multu = 0x18/0x19, div/divu = 0x1A/0x1B).
  - hilo: mfhi/mflo/mthi/mtlo (funct 0x10–0x13) or md.
- Tuse rs:
  - 0 for beq/bne/jr/jalr.
  - 1 for other rs readers.
- Tuse rt:
  - 0 for beq/bne.
  - 1 for R-type ALU/md.
  - 2 for stores.
  - Non-readers never stall.
- Destination and Tnew:
  - Destination: rd for R-type, rt for I-type ALU/load, 31 for jal.
  - Tnew_E: load = 2, other writers = 1.
  - Tnew_M: load = 1, else 0.
  - Destination 0 never hazards.
- RAW stall:
  - Asserted if (D source matches E destination and Tuse < Tnew_E), or (D source matches M destination and Tuse < Tnew_M).
- md stall:
  - md_start = Instr_E is md.
  - Asserted when D is a hilo op and (md_start or md_busy).
- stall = RAW stall OR md stall.
- When stall is asserted, stall_PC = stall_FD = clr_DE = 1 in the same cycle (combinational).
- md counter:
  - On posedge with md_start = 1 and IntReq = 0, load MULT_CYC or DIV_CYC.
  - Otherwise decrement if nonzero.
  - md_busy = (counter != 0), so busy lasts exactly N cycles after the issue edge.
  - md_start is ignored while busy; the D stall guarantees no overlap.
- IntReq priority:
  - clr_FD = clr_DE = clr_EM = 1, stall_PC = stall_FD = 0, regardless of hazards.
  - A running counter keeps counting.
  - An md in E that is flushed does not load the counter.
- stall_cnt:
  - Increments on each posedge where stall = 1 and IntReq = 0.
  - Saturates at all-ones.
- Reset:
  - On reset low, immediately (async): counter = 0, md_busy = 0, stall_cnt = 0.
  - With all-zero (nop) instructions and IntReq = 0, every combinational output is 0.
- Reset mid-operation aborts any busy window with no residual stall.

Test Plan:
- Instr_E = lw $1,0($0); Instr_D = addu $2,$1,$3 -> stall_PC/stall_FD/clr_DE = 1 for one cycle. Next cycle (lw in M, Instr_E = nop) -> no stall; stall_cnt = 1.
- Instr_E = lw $1; Instr_D = beq $1,$0 -> stall 2 cycles: E Tnew 2 > 0, then M Tnew 1 > 0.
- lw $0 in E, addu reading $0 in D -> no stall. sw $1 in D with lw $1 in E (Tuse rt 2 = Tnew 2) -> no stall.
- mult in E, mflo in D -> stall on the issue cycle plus 5 busy cycles (6 total). md_busy high exactly 5 cycles. Repeat with div -> 11 total.
- During div busy (counter = 7), IntReq = 1 -> clr_FD/clr_DE/clr_EM = 1, stall_PC = 0. Counter continues to 6. Separately, div in E with IntReq = 1 -> md_busy stays 0.
- Assert reset low mid-div (counter = 4) between clock edges -> md_busy and stall_cnt go to 0 immediately. Release reset -> no stall with nop inputs.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush controller for the 5-stage MIPS pipeline
// Tuse/Tnew hazard detection, mult/div busy window and exception flush priority.
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr_D,
    input  logic [31:0]      Instr_E,
    input  logic [31:0]      Instr_M,
    input  logic             IntReq,
    output logic             stall_PC,
    output logic             stall_FD,
    output logic             clr_FD,
    output logic             clr_DE,
    output logic             clr_EM,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    // A non-reader gets Tuse 3, which is never below any Tnew (max 2).
    localparam logic [1:0] T_NONE = 2'd3;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == 6'h04) || (op == 6'h05);
    endfunction

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) && (fn inside {[6'h18:6'h1B]});
    endfunction

    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] dst;
        dst = 5'd0;
        if (op == 6'h00)
            dst = rd;
        else if (is_load(op) || (op >= 6'h08 && op <= 6'h0F))
            dst = rt;
        else if (op == 6'h03)
            dst = 5'd31;
        return dst;
    endfunction

    function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] dst, input logic [1:0] tnew);
        return (src == dst) && (tuse < tnew);
    endfunction

    logic [5:0]       op_d, fn_d, op_e, fn_e, op_m;
    logic [4:0]       rs_d, rt_d, dst_e, dst_m;
    logic             rtype_d, jreg_d, hilo_mv_d, hilo_d;
    logic [1:0]       tuse_rs, tuse_rt, tnew_e, tnew_m;
    logic             raw_stall, md_stall, stall;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_busy_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             unused_bits;

    assign op_d = Instr_D[31:26];
    assign fn_d = Instr_D[5:0];
    assign rs_d = Instr_D[25:21];
    assign rt_d = Instr_D[20:16];
    assign op_e = Instr_E[31:26];
    assign fn_e = Instr_E[5:0];
    assign op_m = Instr_M[31:26];
    assign unused_bits = ^{Instr_D[15:6], Instr_E[25:21], Instr_E[10:6],
                           Instr_M[25:21], Instr_M[10:0]};

    always_comb begin
        rtype_d   = (op_d == 6'h00);
        jreg_d    = rtype_d && (fn_d == 6'h08 || fn_d == 6'h09);
        hilo_mv_d = rtype_d && (fn_d inside {[6'h10:6'h13]});
        tuse_rs   = T_NONE;
        tuse_rt   = T_NONE;
        if (is_branch(op_d) || jreg_d)
            tuse_rs = 2'd0;
        else if ((rtype_d && fn_d != 6'h10 && fn_d != 6'h12) ||
                 (op_d >= 6'h08 && op_d <= 6'h0E) || is_load(op_d) || is_store(op_d))
            tuse_rs = 2'd1;
        if (is_branch(op_d))
            tuse_rt = 2'd0;
        else if (rtype_d && !jreg_d && !hilo_mv_d)
            tuse_rt = 2'd1;
        else if (is_store(op_d))
            tuse_rt = 2'd2;
    end

    // Writers to $0 get Tnew 0, so they can never cause a stall.
    assign dst_e  = dest_of(op_e, Instr_E[20:16], Instr_E[15:11]);
    assign dst_m  = dest_of(op_m, Instr_M[20:16], Instr_M[15:11]);
    assign tnew_e = (dst_e == 5'd0) ? 2'd0 : (is_load(op_e) ? 2'd2 : 2'd1);
    assign tnew_m = (dst_m != 5'd0 && is_load(op_m)) ? 2'd1 : 2'd0;

    assign raw_stall = raw_hit(rs_d, tuse_rs, dst_e, tnew_e) |
                       raw_hit(rt_d, tuse_rt, dst_e, tnew_e) |
                       raw_hit(rs_d, tuse_rs, dst_m, tnew_m) |
                       raw_hit(rt_d, tuse_rt, dst_m, tnew_m);

    assign md_start = is_md(op_e, fn_e);
    assign md_busy  = md_busy_q;
    assign hilo_d   = hilo_mv_d || is_md(op_d, fn_d);
    assign md_stall = hilo_d && (md_start || md_busy_q);
    assign stall    = raw_stall || md_stall;

    always_comb begin
        if (IntReq) begin
            stall_PC = 1'b0;
            stall_FD = 1'b0;
            clr_FD   = 1'b1;
            clr_DE   = 1'b1;
            clr_EM   = 1'b1;
        end else begin
            stall_PC = stall;
            stall_FD = stall;
            clr_FD   = 1'b0;
            clr_DE   = stall;
            clr_EM   = 1'b0;
        end
    end

    // A flushed md never loads; a running window keeps counting through a flush.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start && !IntReq && md_cnt_q == '0)
            md_cnt_d = fn_e[1] ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MD_W'(1);
        stall_cnt_d = stall_cnt_q;
        if (stall && !IntReq && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q    <= '0;
            md_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= (md_cnt_d != '0);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
// Expected responses come from an instruction-class reference model.
module tb_hazard_stall_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int NEVER  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_D, Instr_E, Instr_M;
    logic        IntReq;
    logic        stall_PC, stall_FD, clr_FD, clr_DE, clr_EM, md_start, md_busy;
    logic [15:0] stall_cnt;
    logic        s_stall_PC, s_stall_FD, s_clr_FD, s_clr_DE, s_clr_EM, s_md_start, s_md_busy;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Instr_D(Instr_D), .Instr_E(Instr_E), .Instr_M(Instr_M),
        .IntReq(IntReq), .stall_PC(stall_PC), .stall_FD(stall_FD), .clr_FD(clr_FD),
        .clr_DE(clr_DE), .clr_EM(clr_EM), .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .Instr_D(Instr_D), .Instr_E(Instr_E), .Instr_M(Instr_M),
        .IntReq(IntReq), .stall_PC(s_stall_PC), .stall_FD(s_stall_FD), .clr_FD(s_clr_FD),
        .clr_DE(s_clr_DE), .clr_EM(s_clr_EM), .md_start(s_md_start), .md_busy(s_md_busy),
        .stall_cnt(s_stall_cnt)
    );

    typedef enum {K_ALU_R, K_JREG, K_MD, K_MFHL, K_MTHL, K_LOAD, K_STORE,
                  K_BR, K_IALU, K_LUI, K_JAL, K_OTHER} kind_e;

    typedef struct {
        logic [6:0] flags;
        int         cnt;
        int         cnt_small;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;
    int    md_rem = 0;
    int    cnt_model = 0;
    string names[7] = '{"md_busy", "md_start", "clr_EM", "clr_DE", "clr_FD", "stall_FD", "stall_PC"};

    function automatic kind_e kind_of(input logic [31:0] i);
        kind_e k;
        case (i[31:26])
            6'h00: case (i[5:0])
                       6'h08, 6'h09:               k = K_JREG;
                       6'h10, 6'h12:               k = K_MFHL;
                       6'h11, 6'h13:               k = K_MTHL;
                       6'h18, 6'h19, 6'h1A, 6'h1B: k = K_MD;
                       default:                    k = K_ALU_R;
                   endcase
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: k = K_LOAD;
            6'h28, 6'h29, 6'h2B:               k = K_STORE;
            6'h04, 6'h05:                      k = K_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: k = K_IALU;
            6'h0F:                             k = K_LUI;
            6'h03:                             k = K_JAL;
            default:                           k = K_OTHER;
        endcase
        return k;
    endfunction

    function automatic int tuse_of(input logic [31:0] i, input bit rt_port);
        kind_e k;
        k = kind_of(i);
        if (k == K_BR) return 0;
        if (!rt_port) begin
            if (k == K_JREG) return 0;
            if (k inside {K_ALU_R, K_MD, K_MTHL, K_IALU, K_LOAD, K_STORE}) return 1;
        end else begin
            if (k inside {K_ALU_R, K_MD}) return 1;
            if (k == K_STORE) return 2;
        end
        return NEVER;
    endfunction

    function automatic int dest_of(input logic [31:0] i);
        kind_e k;
        k = kind_of(i);
        if (i[31:26] == 6'h00) return int'(i[15:11]);
        if (k inside {K_LOAD, K_IALU, K_LUI}) return int'(i[20:16]);
        if (k == K_JAL) return 31;
        return 0;
    endfunction

    // Cycles until the result exists: loads finish after M, everything else after E.
    function automatic int tnew_of(input logic [31:0] i, input int depth);
        int t;
        t = ((kind_of(i) == K_LOAD) ? 2 : 1) - depth;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] rand_instr();
        int a, b, c;
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        case ($urandom_range(0, 13))
            0:       return 32'h0;
            1:       return rtype(a, b, c, 'h21);
            2:       return itype('h23, a, b);
            3:       return itype('h20, a, b);
            4:       return itype('h2B, a, b);
            5:       return itype('h04, a, b);
            6:       return itype('h05, a, b);
            7:       return rtype(a, 0, 0, 'h08);
            8:       return rtype(a, 0, c, 'h09);
            9:       return rtype(a, b, 0, 'h18 + int'($urandom_range(0, 3)));
            10:      return rtype(a, 0, c, 'h10 + int'($urandom_range(0, 3)));
            11:      return itype('h09, a, b);
            12:      return itype('h0F, 0, b);
            default: return {6'h03, 26'($urandom)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input string tag);
        exp_t        e;
        int          src[2];
        int          tu[2];
        logic [31:0] stg[2];
        int          dst, tn;
        bit          raw, mds, stall, mdst, busy;
        raw    = 1'b0;
        src[0] = int'(Instr_D[25:21]);
        src[1] = int'(Instr_D[20:16]);
        tu[0]  = tuse_of(Instr_D, 1'b0);
        tu[1]  = tuse_of(Instr_D, 1'b1);
        stg[0] = Instr_E;
        stg[1] = Instr_M;
        for (int s = 0; s < 2; s++) begin
            dst = dest_of(stg[s]);
            tn  = tnew_of(stg[s], s);
            for (int j = 0; j < 2; j++)
                if (dst != 0 && src[j] == dst && tu[j] < tn) raw = 1'b1;
        end
        mdst  = (kind_of(Instr_E) == K_MD);
        busy  = (md_rem > 0);
        mds   = (kind_of(Instr_D) inside {K_MD, K_MFHL, K_MTHL}) && (mdst || busy);
        stall = raw || mds;
        e.flags = IntReq ? {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mdst, busy}
                         : {stall, stall, 1'b0, stall, 1'b0, mdst, busy};
        e.cnt       = (cnt_model > 65535) ? 65535 : cnt_model;
        e.cnt_small = (cnt_model > 3) ? 3 : cnt_model;
        e.tag       = tag;
        sb.push_back(e);
        if (reset) begin
            if (mdst && !IntReq && md_rem == 0)
                md_rem = (Instr_E[5:0] >= 6'h1A) ? DIV_N : MULT_N;
            else if (md_rem > 0)
                md_rem--;
            if (stall && !IntReq) cnt_model++;
        end
    endtask

    task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                        input logic irq, input string tag);
        @(posedge clk);
        #2;
        Instr_D = d;
        Instr_E = e;
        Instr_M = m;
        IntReq  = irq;
        issue(tag);
    endtask

    logic [31:0] NOP, LW1, LW0, ADDU213, ADDU0, BEQ10, SW1, MULT, DIV, MFLO;

    task automatic md_seq(input logic [31:0] mdi, input int n, input string tag);
        int busy_seen;
        int c0;
        busy_seen = 0;
        step(MFLO, mdi, NOP, 1'b0, tag);
        #1 c0 = int'(stall_cnt);
        for (int k = 0; k < n + 2; k++) begin
            step(MFLO, NOP, NOP, 1'b0, tag);
            #1 if (md_busy) busy_seen++;
        end
        chk({tag, " stall_cycles"}, 32'(int'(stall_cnt) - c0), 32'(n + 1));
        chk({tag, " busy_cycles"}, 32'(busy_seen), 32'(n));
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] act, sact;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                act  = {stall_PC, stall_FD, clr_FD, clr_DE, clr_EM, md_start, md_busy};
                sact = {s_stall_PC, s_stall_FD, s_clr_FD, s_clr_DE, s_clr_EM, s_md_start, s_md_busy};
                for (int b = 0; b < 7; b++)
                    chk({e.tag, " ", names[b]}, 32'(act[b]), 32'(e.flags[b]));
                chk({e.tag, " stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
                chk({e.tag, " small_flags"}, 32'(sact), 32'(e.flags));
                chk({e.tag, " small_stall_cnt"}, 32'(s_stall_cnt), 32'(e.cnt_small));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : driver
        NOP     = 32'h0;
        LW1     = itype('h23, 0, 1);
        LW0     = itype('h23, 0, 0);
        ADDU213 = rtype(1, 3, 2, 'h21);
        ADDU0   = rtype(0, 3, 2, 'h21);
        BEQ10   = itype('h04, 1, 0);
        SW1     = itype('h2B, 0, 1);
        MULT    = rtype(1, 2, 0, 'h18);
        DIV     = rtype(1, 2, 0, 'h1A);
        MFLO    = rtype(0, 0, 4, 'h12);
        reset = 1'b0;
        Instr_D = NOP; Instr_E = NOP; Instr_M = NOP; IntReq = 1'b0;

        step(NOP, NOP, NOP, 1'b0, "reset");
        #4 reset = 1'b1;

        step(ADDU213, LW1, NOP, 1'b0, "lu_stall");
        step(ADDU213, NOP, LW1, 1'b0, "lu_clear");
        #1 chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        begin : branch_case
            int c0;
            step(BEQ10, LW1, NOP, 1'b0, "br_e");
            #1 c0 = int'(stall_cnt);
            step(BEQ10, NOP, LW1, 1'b0, "br_m");
            step(BEQ10, NOP, NOP, 1'b0, "br_go");
            step(NOP, NOP, NOP, 1'b0, "br_after");
            #1 chk("br_stall_cycles", 32'(int'(stall_cnt) - c0), 32'd2);
        end

        step(ADDU0, LW0, NOP, 1'b0, "reg0");
        #1 chk("reg0_no_stall", 32'(stall_PC), 32'd0);
        step(SW1, LW1, NOP, 1'b0, "sw_tuse2");
        #1 chk("sw_no_stall", 32'(stall_PC), 32'd0);

        md_seq(MULT, MULT_N, "mult");
        md_seq(DIV, DIV_N, "div");

        step(MFLO, DIV, NOP, 1'b0, "irq_issue");
        repeat (3) step(MFLO, NOP, NOP, 1'b0, "irq_wait");
        step(MFLO, NOP, NOP, 1'b1, "irq_flush");
        #1;
        chk("irq_clr_FD", 32'(clr_FD), 32'd1);
        chk("irq_clr_EM", 32'(clr_EM), 32'd1);
        chk("irq_stall_PC", 32'(stall_PC), 32'd0);
        step(NOP, NOP, NOP, 1'b0, "irq_after");
        #1 chk("irq_busy_continues", 32'(md_busy), 32'd1);
        repeat (7) step(NOP, NOP, NOP, 1'b0, "irq_drain");
        step(NOP, DIV, NOP, 1'b1, "irq_kill");
        step(NOP, NOP, NOP, 1'b0, "irq_kill_chk");
        #1 chk("irq_kill_busy", 32'(md_busy), 32'd0);

        step(NOP, DIV, NOP, 1'b0, "rst_issue");
        repeat (6) step(NOP, NOP, NOP, 1'b0, "rst_wait");
        @(posedge clk);
        #2;
        chk("rst_pre_busy", 32'(md_busy), 32'd1);
        reset = 1'b0;
        md_rem = 0;
        cnt_model = 0;
        issue("rst_mid");
        #1;
        chk("rst_async_busy", 32'(md_busy), 32'd0);
        chk("rst_async_cnt", 32'(stall_cnt), 32'd0);
        #4 reset = 1'b1;
        step(NOP, NOP, NOP, 1'b0, "rst_release");
        step(MFLO, NOP, NOP, 1'b0, "rst_no_residual");

        for (int n = 0; n < 400; n++)
            step(rand_instr(), rand_instr(), rand_instr(), ($urandom_range(0, 9) == 0), "rand");

        @(negedge clk);
        #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
